regfile_mp: RTL

- Parametrised multi-read-port register file; next generation of the single-port regfile.
- One write port with active-low write enable and byte enables; N_RD independent registered read ports.
- Same-cycle write-to-read bypass, optional hardwired-zero entry 0, sticky address-range error flag.
- Used as the CPU general-purpose register file and as a generic small storage array.

---
 rtl/regfile_mp_pkg.sv | 19 +
 rtl/regfile_mp_rdport.sv | 56 +++++
 rtl/regfile_mp.sv | 113 +++++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and constants for the multi-port register file.
// Imported by the top level and the read-port sub-module.
package regfile_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned N_RD_DEF   = 2;

  // Write enable is active-low.
  localparam logic ENABLE_ = 1'b0;
  localparam logic HIGH    = 1'b1;
  localparam logic LOW     = 1'b0;

  function automatic int unsigned n_lanes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// One registered read port with same-edge write bypass and range check.
// Produces a single-cycle range-error pulse for the top-level sticky flag.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_merged,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic              in_range;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  assign in_range = ({1'b0, rd_addr} < DEPTH_A);
  assign rd_idx   = in_range ? rd_addr : '0;
  assign rd_err   = rd_en & ~in_range;
  assign rd_data  = rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en == HIGH) begin
      if (!in_range) begin
        rd_data_d = '0;
      end else if (wr_fire && (wr_idx == rd_addr)) begin
        // wr_fire already excludes discarded writes, so the merged word is the post-write value
        rd_data_d = wr_merged;
      end else begin
        rd_data_d = mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: one byte-enabled write port, N_RD registered
// read ports with bypass, optional hardwired-zero entry 0, sticky range error.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned N_RD    = N_RD_DEF,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int unsigned     LANES   = n_lanes(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              wr_req;
  logic              wr_in_range;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_merged;
  logic [N_RD-1:0]   rd_err;
  logic              err_d;
  logic              err_q;

  assign wr_req      = (we_ == ENABLE_);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_A);
  assign wr_idx      = wr_in_range ? wr_addr : '0;
  assign wr_fire     = wr_req && wr_in_range && !(ZERO_R0 && (wr_addr == '0));

  always_comb begin
    wr_merged = mem_q[wr_idx];
    for (int unsigned b = 0; b < LANES; b++) begin
      if (wr_be[b]) begin
        wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[wr_idx] = wr_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_RD; k++) begin : g_rd
      regfile_mp_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_rdport (
        .clk       (clk),
        .reset     (reset),
        .mem       (mem_q),
        .wr_fire   (wr_fire),
        .wr_idx    (wr_idx),
        .wr_merged (wr_merged),
        .rd_en     (rd_en[k]),
        .rd_addr   (rd_addr[k*ADDR_W +: ADDR_W]),
        .rd_data   (rd_data[k*DATA_W +: DATA_W]),
        .rd_err    (rd_err[k])
      );
    end
  endgenerate

  // Set dominates clear when both happen at the same edge.
  always_comb begin
    err_d = err_q;
    if ((wr_req && !wr_in_range) || (|rd_err)) begin
      err_d = HIGH;
    end else if (err_clr) begin
      err_d = LOW;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= LOW;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule
